// File: rtl/current_switch_bank.sv
// Bank of N_CH binary-weighted current switches with break-before-make code sequencing
// and a first-order load filter. Define CURRENT_SWITCH_BANK_SETTLE_EN to add the settled flag.
module current_switch_bank #(
  parameter int N_CH        = 4,
  parameter int WIDTH       = 16,
  parameter int I_UNIT      = 1000,
  parameter int V_MIN       = 0,
  parameter int ALPHA_SHIFT = 2,
  parameter int DEAD_CYCLES = 2
`ifdef CURRENT_SWITCH_BANK_SETTLE_EN
  ,
  parameter int SETTLE_TOL  = 4
`endif
) (
  input  logic                    emu_clk,
  input  logic                    emu_rst,
  input  logic signed [WIDTH-1:0] v_in,
  input  logic [N_CH-1:0]         code,
  input  logic                    code_valid,
  output logic                    code_ready,
  output logic [N_CH-1:0]         sw_state,
  output logic                    busy,
  output logic signed [WIDTH-1:0] v_out
`ifdef CURRENT_SWITCH_BANK_SETTLE_EN
  ,
  output logic                    settled
`endif
);

  localparam int     CW      = (DEAD_CYCLES < 2) ? 1 : $clog2(DEAD_CYCLES + 1);
  localparam longint SAT_MAX = (longint'(1) << (WIDTH - 1)) - 1;
  localparam longint SAT_MIN = -(longint'(1) << (WIDTH - 1));

  typedef enum logic {S_IDLE, S_BREAK} state_t;

  state_t                  r_state,     w_state_nxt;
  logic [CW-1:0]           r_cnt,       w_cnt_nxt;
  logic [N_CH-1:0]         r_pending,   w_pending_nxt;
  logic [N_CH-1:0]         r_sw_state,  w_sw_nxt;
  logic signed [WIDTH-1:0] r_v_out,     w_v_out_nxt;
  logic                    w_accept;
  longint                  w_prod;
  logic signed [WIDTH-1:0] w_v_tgt;
  logic signed [WIDTH:0]   w_diff;
  logic signed [WIDTH:0]   w_step;

  assign code_ready = (r_state == S_IDLE) && !emu_rst;
  assign w_accept   = code_valid && code_ready;
  assign busy       = (r_state == S_BREAK);
  assign sw_state   = r_sw_state;
  assign v_out      = r_v_out;

  // NOTE: every signal written here gets a default first, so no branch can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = r_pending;
    w_sw_nxt      = r_sw_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_pending_nxt = code;
          if (code != r_sw_state) begin
            if (DEAD_CYCLES == 0) begin
              w_sw_nxt = code;
            end else begin
              // Break phase: drop switches immediately, hold new ones until the dead time expires.
              w_sw_nxt    = r_sw_state & code;
              w_cnt_nxt   = CW'(DEAD_CYCLES);
              w_state_nxt = S_BREAK;
            end
          end
        end
      end
      S_BREAK: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          w_sw_nxt    = r_pending;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_prod = longint'(I_UNIT) * longint'(r_sw_state);
    if (v_in < V_MIN)           w_v_tgt = '0;
    else if (w_prod > SAT_MAX)  w_v_tgt = WIDTH'(SAT_MAX);
    else if (w_prod < SAT_MIN)  w_v_tgt = WIDTH'(SAT_MIN);
    else                        w_v_tgt = WIDTH'(w_prod);

    w_diff = {w_v_tgt[WIDTH-1], w_v_tgt} - {r_v_out[WIDTH-1], r_v_out};
    w_step = w_diff >>> ALPHA_SHIFT;
    // Minimum step of one LSB so the filter lands exactly on the target.
    if (w_step == '0 && w_diff != '0) w_step = w_diff[WIDTH] ? '1 : (WIDTH+1)'(1);
    w_v_out_nxt = WIDTH'({r_v_out[WIDTH-1], r_v_out} + w_step);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pending  <= '0;
      r_sw_state <= '0;
      r_v_out    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pending  <= w_pending_nxt;
      r_sw_state <= w_sw_nxt;
      r_v_out    <= w_v_out_nxt;
    end
  end

`ifdef CURRENT_SWITCH_BANK_SETTLE_EN
  logic [WIDTH:0] w_abs_diff;
  logic           w_in_tol;
  logic [1:0]     r_settle_cnt;

  assign w_abs_diff = w_diff[WIDTH] ? -w_diff : w_diff;
  assign w_in_tol   = (w_abs_diff <= (WIDTH+1)'(SETTLE_TOL)) && !busy;
  // Counter holds the number of prior in-tolerance cycles; the current one makes the fourth.
  assign settled    = w_in_tol && (r_settle_cnt == 2'd3);

  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst)                    r_settle_cnt <= '0;
    else if (!w_in_tol)             r_settle_cnt <= '0;
    else if (r_settle_cnt != 2'd3)  r_settle_cnt <= r_settle_cnt + 2'd1;
  end
`endif

endmodule

// File: doc/current_switch_bank.md
Name: current_switch_bank

Overview:
- Parametrised, multi-channel successor to the single current switch model for anasymod FPGA emulation.
- Contains N_CH binary-weighted current switches driven by a code accepted over a valid/ready handshake.
- Code changes use break-before-make sequencing with a programmable dead time.
- The summed current is converted to an output voltage through a first-order discrete-time load filter. All analog quantities are signed fixed-point, one update per emu_clk.

Parameters:
- N_CH, 4, number of switches; channel k has weight 2^k.
- WIDTH, 16, signed fixed-point width of v_in, v_out and internal voltages.
- I_UNIT, 1000, voltage LSBs contributed by weight 1 into the load; signed, must be positive.
- V_MIN, 0, minimum v_in (signed LSBs) for the switches to conduct (compliance).
- ALPHA_SHIFT, 2, filter coefficient 2^-ALPHA_SHIFT per cycle; range 0..WIDTH-1.
- DEAD_CYCLES, 2, break interval in emu_clk cycles; 0 disables the break phase.

Ports:
- emu_clk  in  1  emulator clock.
- emu_rst  in  1  reset, asynchronous, active-high.
- v_in  in  WIDTH  signed supply/compliance voltage.
- code  in  N_CH  requested switch pattern.
- code_valid  in  1  code is presented.
- code_ready  out  1  block accepts a code this cycle.
- sw_state  out  N_CH  switches currently conducting.
- busy  out  1  break sequence in progress.
- v_out  out  WIDTH  signed filtered output voltage.

Behaviour:
- Reset (async assert, sync release): sw_state=0, v_out=0, state=IDLE, dead counter=0, busy=0.
- code_ready is combinational: 1 in IDLE, 0 in BREAK; forced 0 while emu_rst=1.
- Accept on a rising edge with code_valid=1 and code_ready=1. code is sampled into a pending register.
- IDLE, accept, code==sw_state: no change, stay IDLE, code_ready stays 1.
- IDLE, accept, code!=sw_state, DEAD_CYCLES>0:
  - sw_state<=sw_state&code: turn-offs take effect immediately, turn-ons are held.
  - Load counter=DEAD_CYCLES and enter BREAK.
- IDLE, accept, DEAD_CYCLES==0: sw_state<=code directly, stay IDLE.
- BREAK:
  - Counter decrements each cycle; code_valid is ignored.
  - On the edge where counter==1: sw_state<=pending, go to IDLE.
  - code_ready is therefore low for exactly DEAD_CYCLES cycles.
- busy = (state==BREAK).
- Target voltage v_tgt is combinational:
  - v_tgt = I_UNIT*sw_state when v_in>=V_MIN (signed compare), else v_tgt=0.
  - Product is computed at full width and saturated to the signed WIDTH range [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Filter, each cycle:
  - d = v_tgt - v_out at WIDTH+1 bits; step = d>>>ALPHA_SHIFT (arithmetic shift).
  - If step==0 and d!=0, step=sign(d) (±1), which guarantees exact convergence.
  - v_out <= v_out + step. v_out never overshoots v_tgt and never wraps.
- sw_state affects v_tgt in the same cycle it updates, so v_out responds on the following edge.
- Reset mid-BREAK: pending code is discarded and all state returns to reset values.

Optional Feature:
- Macro: CURRENT_SWITCH_BANK_SETTLE_EN.
- Defined:
  - Adds output port settled (1 bit) and parameter SETTLE_TOL (default 4).
  - settled=1 when |v_tgt - v_out| <= SETTLE_TOL for 4 consecutive cycles and busy=0.
  - Clears in the same cycle either condition fails. Reset value 0.
- Undefined: no port, no parameter, no logic; all other behaviour is identical.

Test Plan:
- Reset then release, v_in=100, code_valid=0 -> sw_state=0, v_out=0, code_ready=1, busy=0.
- From sw_state=0011, accept code=0101 with DEAD_CYCLES=2:
  - Cycle after accept: sw_state=0001, busy=1, code_ready=0 for 2 cycles.
  - Then sw_state=0101, busy=0.
- From v_out=0, sw_state set to 0101, ALPHA_SHIFT=2, I_UNIT=1000:
  - v_out sequence is 1250, 2187, 2890, ...
  - Reaches exactly 5000 and holds.
- Accept code equal to sw_state -> code_ready stays 1, busy never asserts, sw_state and v_out unchanged.
- Drop v_in below V_MIN with sw_state=1111 -> v_tgt=0, v_out decays monotonically to 0, sw_state still 1111.
- With I_UNIT=5000, WIDTH=16, code=1111 -> v_tgt saturates at 32767 and v_out converges to 32767 without wrap.
- Assert emu_rst mid-BREAK -> all outputs reset immediately and the pending code is never applied.
